// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the decode bubble encoding, the architectural reset PC, the PC step
// and the packed {instr, pc_plus4} entry stored in the queue.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0040_0020;
  localparam logic [31:0] PC_INCR   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

  // PC + 4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  function automatic fetch_entry_t make_entry(input logic [31:0] instr,
                                              input logic [31:0] pc);
    fetch_entry_t e;
    e.instr    = instr;
    e.pc_plus4 = pc + PC_INCR;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage array for the fetch queue.
// DEPTH x 64-bit registers, one synchronous write port and one asynchronous
// read port. The array has no reset; validity is tracked by the queue control.
//   clk    : rising-edge clock
//   we     : write enable
//   waddr  : write index
//   wdata  : entry to write
//   raddr  : read index
//   rdata  : entry at raddr (combinational)
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t  rdata
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer between fetch and decode.
// Captures {instr, PC+4} pairs from fetch and presents them in order to decode,
// letting fetch run ahead while decode is stalled. A flush (taken branch/jump)
// empties the queue in one cycle. No bypass: a pushed entry is visible to
// decode only after the edge that stores it.
//   clk, reset     : clock, asynchronous active-high reset
//   push_valid     : fetch presents an instruction
//   push_instr     : instruction word
//   push_pc        : PC of push_instr
//   push_ready     : queue has room (fetch register enable)
//   pop_ready      : decode consumes the head this cycle
//   pop_valid      : head entry valid
//   pop_instr      : head instruction, NOP when empty
//   pop_pc_plus4   : head PC+4, 0 when empty
//   flush          : discard all entries
//   count          : occupied entries, 0..DEPTH
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [31:0]              push_instr,
  input  logic [31:0]              push_pc,
  output logic                     push_ready,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output logic [31:0]              pop_instr,
  output logic [31:0]              pop_pc_plus4,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic         push_fire;
  logic         pop_fire;
  logic         mem_we;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;

  // Both handshake qualifiers come from registered state only, so there is no
  // combinational path from pop_ready to push_ready.
  assign push_ready = (count_q != FULL_COUNT);
  assign pop_valid  = (count_q != '0);

  assign push_fire = push_valid && push_ready;
  assign pop_fire  = pop_valid && pop_ready;

  // A push coinciding with flush is discarded, so don't write the array.
  assign mem_we   = push_fire && !flush;
  assign wr_entry = make_entry(push_instr, push_pc);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  // Empty queue shows a bubble to decode rather than stale storage.
  assign pop_instr    = pop_valid ? head_entry.instr    : NOP_INSTR;
  assign pop_pc_plus4 = pop_valid ? head_entry.pc_plus4 : 32'h0;
  assign count        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid;
  logic [31:0] push_instr;
  logic [31:0] push_pc;
  logic        push_ready;
  logic        pop_ready;
  logic        pop_valid;
  logic [31:0] pop_instr;
  logic [31:0] pop_pc_plus4;
  logic        flush;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push_valid   (push_valid),
    .push_instr   (push_instr),
    .push_pc      (push_pc),
    .push_ready   (push_ready),
    .pop_ready    (pop_ready),
    .pop_valid    (pop_valid),
    .pop_instr    (pop_instr),
    .pop_pc_plus4 (pop_pc_plus4),
    .flush        (flush),
    .count        (count)
  );

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    push_valid = 1'b0;
    push_instr = '0;
    push_pc    = '0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    #3;
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", count);
    end
    checks++;
    if (pop_valid !== 1'b0) begin
      failures++; $display("FAIL reset_pop_valid got=%b exp=0", pop_valid);
    end
    checks++;
    if (pop_instr !== 32'h0 || pop_pc_plus4 !== 32'h0) begin
      failures++; $display("FAIL reset_outputs got=%h/%h exp=0/0", pop_instr, pop_pc_plus4);
    end
    checks++;
    if (push_ready !== 1'b1) begin
      failures++; $display("FAIL reset_push_ready got=%b exp=1", push_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_in_order();
    logic [31:0] exp_instr [3];
    logic [31:0] exp_pc4   [3];
    exp_instr[0] = 32'h2010_0001; exp_pc4[0] = 32'h0040_0024;
    exp_instr[1] = 32'h2010_0002; exp_pc4[1] = 32'h0040_0028;
    exp_instr[2] = 32'h2010_0003; exp_pc4[2] = 32'h0040_002C;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_instr = exp_instr[i];
      push_pc    = exp_pc4[i] - 32'd4;
      tick();
    end
    push_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      failures++; $display("FAIL order_count got=%0d exp=3", count);
    end
    checks++;
    if (pop_pc_plus4 !== 32'h0040_0024) begin
      failures++; $display("FAIL order_head_pc4 got=%h exp=00400024", pop_pc_plus4);
    end
    pop_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pop_valid !== 1'b1 || pop_instr !== exp_instr[i] || pop_pc_plus4 !== exp_pc4[i]) begin
        failures++;
        $display("FAIL order_pop%0d got=%b/%h/%h exp=1/%h/%h", i, pop_valid, pop_instr,
                 pop_pc_plus4, exp_instr[i], exp_pc4[i]);
      end
      tick();
    end
    checks++;
    if (pop_valid !== 1'b0 || pop_instr !== 32'h0 || count !== 3'd0) begin
      failures++;
      $display("FAIL order_empty got=%b/%h/%0d exp=0/0/0", pop_valid, pop_instr, count);
    end
    // Popping an empty queue changes nothing.
    tick();
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0) begin
      failures++; $display("FAIL pop_empty got=%0d/%b exp=0/0", count, pop_valid);
    end
    pop_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_instr = 32'hA0 + i;
      push_pc    = 32'h1000 + 4 * i;
      tick();
    end
    checks++;
    if (count !== 3'd4 || push_ready !== 1'b0) begin
      failures++; $display("FAIL full_state got=%0d/%b exp=4/0", count, push_ready);
    end
    // Fifth push is held by fetch.
    push_instr = 32'hA4;
    push_pc    = 32'h1010;
    tick();
    checks++;
    if (count !== 3'd4 || pop_instr !== 32'hA0) begin
      failures++; $display("FAIL full_hold got=%0d/%h exp=4/000000a0", count, pop_instr);
    end
    // No combinational path pop_ready -> push_ready.
    pop_ready = 1'b1;
    #1;
    checks++;
    if (push_ready !== 1'b0) begin
      failures++; $display("FAIL full_comb_path got=%b exp=0", push_ready);
    end
    tick();
    pop_ready = 1'b0;
    checks++;
    if (count !== 3'd3 || push_ready !== 1'b1) begin
      failures++; $display("FAIL full_after_pop got=%0d/%b exp=3/1", count, push_ready);
    end
    tick();
    push_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      failures++; $display("FAIL full_held_accept got=%0d exp=4", count);
    end
    pop_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (pop_instr !== 32'hA0 + i || pop_pc_plus4 !== 32'h1004 + 4 * i) begin
        failures++;
        $display("FAIL full_drain%0d got=%h/%h exp=%h/%h", i, pop_instr, pop_pc_plus4,
                 32'hA0 + i, 32'h1004 + 4 * i);
      end
      tick();
    end
    pop_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      push_valid = 1'b1;
      push_instr = 32'hB0 + i;
      push_pc    = 32'h2000 + 4 * i;
      tick();
    end
    pop_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_instr = 32'hB2 + i;
      push_pc    = 32'h2008 + 4 * i;
      checks++;
      if (count !== 3'd2 || pop_instr !== 32'hB0 + i || pop_pc_plus4 !== 32'h2004 + 4 * i) begin
        failures++;
        $display("FAIL b2b_cycle%0d got=%0d/%h/%h exp=2/%h/%h", i, count, pop_instr,
                 pop_pc_plus4, 32'hB0 + i, 32'h2004 + 4 * i);
      end
      tick();
    end
    push_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      checks++;
      if (pop_instr !== 32'hB0 + i) begin
        failures++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, pop_instr, 32'hB0 + i);
      end
      tick();
    end
    pop_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL b2b_final_count got=%0d exp=0", count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_instr = 32'hC0 + i;
      push_pc    = 32'h3000 + 4 * i;
      tick();
    end
    push_instr = 32'hC3;
    push_pc    = 32'h300C;
    pop_ready  = 1'b1;
    flush      = 1'b1;
    tick();
    flush      = 1'b0;
    pop_ready  = 1'b0;
    push_valid = 1'b0;
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || pop_instr !== 32'h0) begin
      failures++;
      $display("FAIL flush_empty got=%0d/%b/%h exp=0/0/0", count, pop_valid, pop_instr);
    end
    push_valid = 1'b1;
    push_instr = 32'hD0;
    push_pc    = 32'h4000;
    tick();
    push_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || pop_instr !== 32'hD0 || pop_pc_plus4 !== 32'h4004) begin
      failures++;
      $display("FAIL flush_after got=%0d/%h/%h exp=1/000000d0/00004004", count, pop_instr,
               pop_pc_plus4);
    end
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    checks++;
    if (count !== 3'd0 || push_ready !== 1'b1 || pop_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle got=%0d/%b/%b exp=0/1/0", count, push_ready, pop_valid);
    end
  endtask

  task automatic test_pc_wrap_and_async_reset();
    push_valid = 1'b1;
    push_instr = 32'h1234_5678;
    push_pc    = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (pop_pc_plus4 !== 32'h0 || pop_valid !== 1'b1 || pop_instr !== 32'h1234_5678) begin
      failures++;
      $display("FAIL pc_wrap got=%b/%h/%h exp=1/12345678/00000000", pop_valid, pop_instr,
               pop_pc_plus4);
    end
    push_instr = 32'h1111_1111;
    push_pc    = 32'h0;
    tick();
    push_valid = 1'b0;
    checks++;
    if (count !== 3'd2) begin
      failures++; $display("FAIL pre_reset_count got=%0d exp=2", count);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got=%0d/%b/%b exp=0/0/1", count, pop_valid, push_ready);
    end
    #2;
    reset = 1'b0;
  endtask

  task automatic test_latency();
    push_valid = 1'b1;
    push_instr = 32'hE0;
    push_pc    = 32'h5000;
    #1;
    checks++;
    if (pop_valid !== 1'b0) begin
      failures++; $display("FAIL latency_before got=%b exp=0", pop_valid);
    end
    tick();
    push_valid = 1'b0;
    checks++;
    if (pop_valid !== 1'b1 || count !== 3'd1 || pop_instr !== 32'hE0) begin
      failures++;
      $display("FAIL latency_after got=%b/%0d/%h exp=1/1/000000e0", pop_valid, count, pop_instr);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_back_to_back();
    test_flush();
    test_pc_wrap_and_async_reset();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
